// File: rtl/oven_pkg.sv
// Shared definitions for the oven cook controller: state encoding, step tables
// and the default limit values used as parameter defaults by the top level.
package oven_pkg;

  typedef enum logic [2:0] {
    ST_OFF      = 3'd0,
    ST_SET_TEMP = 3'd1,
    ST_SET_TIME = 3'd2,
    ST_COOK     = 3'd3,
    ST_DONE     = 3'd4
  } state_e;

  localparam int STEP_W       = 9;
  localparam int TEMP_DEFAULT = 300;
  localparam int TEMP_MIN     = 65;
  localparam int TEMP_MAX     = 500;
  localparam int TIME_MAX     = 1800;

  // Only a clean one-hot selection gives a nonzero step.
  function automatic logic [STEP_W-1:0] temp_step(input logic [4:0] sel);
    case (sel)
      5'b00001: return 9'd5;
      5'b00010: return 9'd10;
      5'b00100: return 9'd25;
      5'b01000: return 9'd50;
      5'b10000: return 9'd100;
      default:  return 9'd0;
    endcase
  endfunction

  function automatic logic [STEP_W-1:0] time_step(input logic [4:0] sel);
    case (sel)
      5'b00001: return 9'd5;
      5'b00010: return 9'd10;
      5'b00100: return 9'd30;
      5'b01000: return 9'd60;
      5'b10000: return 9'd300;
      default:  return 9'd0;
    endcase
  endfunction

endpackage

// File: rtl/key_event.sv
// Synchronises both active-low keys and turns them into one-cycle registered
// inc / dec / confirm events (3 clk from raw press to event).
module key_event (
  input  logic clk,
  input  logic rst,
  input  logic key_inc_n,
  input  logic key_dec_n,
  output logic inc_evt,
  output logic dec_evt,
  output logic cfm_evt
);

  logic [1:0] inc_sync_q, dec_sync_q;
  logic       inc_prev_q, dec_prev_q;
  logic       armed_q;
  logic       inc_evt_q, dec_evt_q, cfm_evt_q;
  logic       inc_s, dec_s, both_low;

  assign inc_s    = inc_sync_q[1];
  assign dec_s    = dec_sync_q[1];
  assign both_low = !inc_s && !dec_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      inc_sync_q <= 2'b11;
      dec_sync_q <= 2'b11;
      inc_prev_q <= 1'b1;
      dec_prev_q <= 1'b1;
      armed_q    <= 1'b1;
      inc_evt_q  <= 1'b0;
      dec_evt_q  <= 1'b0;
      cfm_evt_q  <= 1'b0;
    end else begin
      inc_sync_q <= {inc_sync_q[0], key_inc_n};
      dec_sync_q <= {dec_sync_q[0], key_dec_n};
      inc_prev_q <= inc_s;
      dec_prev_q <= dec_s;
      // A single-key edge only counts while the other key is still released.
      inc_evt_q  <= inc_prev_q && !inc_s && dec_s;
      dec_evt_q  <= dec_prev_q && !dec_s && inc_s;
      cfm_evt_q  <= both_low && armed_q;
      if (both_low)
        armed_q <= 1'b0;
      else if (inc_s && dec_s)
        armed_q <= 1'b1;
    end
  end

  assign inc_evt = inc_evt_q;
  assign dec_evt = dec_evt_q;
  assign cfm_evt = cfm_evt_q;

endmodule

// File: rtl/oven_cook_ctrl.sv
// Oven cook controller: temperature/time entry FSM with saturating updates,
// a 1 s prescaler and the cook countdown with pause and done indication.
module oven_cook_ctrl
  import oven_pkg::*;
#(
  parameter int TEMP_W       = 10,
  parameter int TIME_W       = 13,
  parameter int TEMP_DEFAULT = oven_pkg::TEMP_DEFAULT,
  parameter int TEMP_MIN     = oven_pkg::TEMP_MIN,
  parameter int TEMP_MAX     = oven_pkg::TEMP_MAX,
  parameter int TIME_MAX     = oven_pkg::TIME_MAX,
  parameter int TICK_DIV     = 50000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pwr,
  input  logic              key_inc_n,
  input  logic              key_dec_n,
  input  logic [5:0]        sw,
  output logic [2:0]        state,
  output logic [TEMP_W-1:0] target_temp,
  output logic [TIME_W-1:0] target_time,
  output logic [TIME_W-1:0] remain_time,
  output logic              heater_on,
  output logic              done_pulse
);

  localparam int PS_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PS_W-1:0]   PS_LAST     = PS_W'(TICK_DIV - 1);
  localparam logic [TEMP_W:0]   TEMP_MIN_X  = (TEMP_W + 1)'(TEMP_MIN);
  localparam logic [TEMP_W:0]   TEMP_MAX_X  = (TEMP_W + 1)'(TEMP_MAX);
  localparam logic [TIME_W:0]   TIME_MAX_X  = (TIME_W + 1)'(TIME_MAX);

  state_e            state_q;
  logic [TEMP_W-1:0] temp_q;
  logic [TIME_W-1:0] time_q, remain_q;
  logic [PS_W-1:0]   ps_q;
  logic              heater_q, done_q;
  logic              inc_evt, dec_evt, cfm_evt;

  key_event u_key_event (
    .clk       (clk),
    .rst       (rst),
    .key_inc_n (key_inc_n),
    .key_dec_n (key_dec_n),
    .inc_evt   (inc_evt),
    .dec_evt   (dec_evt),
    .cfm_evt   (cfm_evt)
  );

  // One extra bit on every sum/difference so overflow and underflow are visible.
  logic [TEMP_W:0]   temp_up_w, temp_dn_w;
  logic [TIME_W:0]   time_up_w, time_dn_w;
  logic [TEMP_W-1:0] temp_inc_d, temp_dec_d;
  logic [TIME_W-1:0] time_inc_d, time_dec_d;

  assign temp_up_w  = {1'b0, temp_q} + (TEMP_W + 1)'(temp_step(sw[4:0]));
  assign temp_dn_w  = {1'b0, temp_q} - (TEMP_W + 1)'(temp_step(sw[4:0]));
  assign time_up_w  = {1'b0, time_q} + (TIME_W + 1)'(time_step(sw[4:0]));
  assign time_dn_w  = {1'b0, time_q} - (TIME_W + 1)'(time_step(sw[4:0]));

  assign temp_inc_d = (temp_up_w > TEMP_MAX_X) ? TEMP_MAX_X[TEMP_W-1:0] : temp_up_w[TEMP_W-1:0];
  assign temp_dec_d = (temp_dn_w[TEMP_W] || temp_dn_w < TEMP_MIN_X) ? TEMP_MIN_X[TEMP_W-1:0]
                                                                    : temp_dn_w[TEMP_W-1:0];
  assign time_inc_d = (time_up_w > TIME_MAX_X) ? TIME_MAX_X[TIME_W-1:0] : time_up_w[TIME_W-1:0];
  assign time_dec_d = time_dn_w[TIME_W] ? '0 : time_dn_w[TIME_W-1:0];

  always_ff @(posedge clk) begin
    if (rst || !pwr) begin
      state_q  <= ST_OFF;
      temp_q   <= TEMP_W'(TEMP_DEFAULT);
      time_q   <= '0;
      remain_q <= '0;
      ps_q     <= '0;
      heater_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      heater_q <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        ST_OFF: state_q <= ST_SET_TEMP;
        ST_SET_TEMP: begin
          if (cfm_evt)      state_q <= ST_SET_TIME;
          else if (inc_evt) temp_q  <= temp_inc_d;
          else if (dec_evt) temp_q  <= temp_dec_d;
        end
        ST_SET_TIME: begin
          if (cfm_evt) begin
            if (time_q != '0) begin
              remain_q <= time_q;
              ps_q     <= '0;
              state_q  <= ST_COOK;
              heater_q <= !sw[5];
            end
          end else if (inc_evt) begin
            time_q <= time_inc_d;
          end else if (dec_evt) begin
            time_q <= time_dec_d;
          end
        end
        ST_COOK: begin
          if (cfm_evt) begin
            state_q  <= ST_SET_TEMP;
            remain_q <= '0;
            ps_q     <= '0;
          end else begin
            heater_q <= !sw[5];
            if (!sw[5]) begin
              if (ps_q == PS_LAST) begin
                ps_q <= '0;
                if (remain_q <= TIME_W'(1)) begin
                  remain_q <= '0;
                  state_q  <= ST_DONE;
                  done_q   <= 1'b1;
                  heater_q <= 1'b0;
                end else begin
                  remain_q <= remain_q - TIME_W'(1);
                end
              end else begin
                ps_q <= ps_q + PS_W'(1);
              end
            end
          end
        end
        ST_DONE: begin
          remain_q <= '0;
          if (cfm_evt) state_q <= ST_SET_TEMP;
        end
        default: state_q <= ST_OFF;
      endcase
    end
  end

  assign state       = state_q;
  assign target_temp = temp_q;
  assign target_time = time_q;
  assign remain_time = remain_q;
  assign heater_on   = heater_q;
  assign done_pulse  = done_q;

endmodule

// File: tb/tb_oven_cook_ctrl.sv
// Directed bench for oven_cook_ctrl with a 4-cycle tick; inputs change and
// outputs are sampled on the falling clock edge.
module tb_oven_cook_ctrl;

  logic        clk = 1'b0;
  logic        rst, pwr, key_inc_n, key_dec_n;
  logic [5:0]  sw;
  logic [2:0]  state;
  logic [9:0]  target_temp;
  logic [12:0] target_time, remain_time;
  logic        heater_on, done_pulse;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  oven_cook_ctrl #(.TICK_DIV(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .pwr         (pwr),
    .key_inc_n   (key_inc_n),
    .key_dec_n   (key_dec_n),
    .sw          (sw),
    .state       (state),
    .target_temp (target_temp),
    .target_time (target_time),
    .remain_time (remain_time),
    .heater_on   (heater_on),
    .done_pulse  (done_pulse)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic press(input bit inc, input int n);
    for (int i = 0; i < n; i++) begin
      if (inc) key_inc_n = 1'b0; else key_dec_n = 1'b0;
      repeat (4) @(negedge clk);
      key_inc_n = 1'b1;
      key_dec_n = 1'b1;
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic confirm(input int hold);
    key_inc_n = 1'b0;
    key_dec_n = 1'b0;
    repeat (hold) @(negedge clk);
    key_inc_n = 1'b1;
    key_dec_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout state=%0d remain=%0d", state, remain_time);
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    rst = 1'b1; pwr = 1'b1; sw = 6'b000100;
    key_inc_n = 1'b1; key_dec_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_state",  state, 0);
    chk("rst_temp",   target_temp, 300);
    chk("rst_time",   target_time, 0);
    chk("rst_remain", remain_time, 0);
    chk("rst_heater", heater_on, 0);
    chk("rst_done",   done_pulse, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("set_temp_entry", state, 1);

    // temperature up in steps of 25, clamped at 500
    press(1'b1, 3);  chk("temp_375", target_temp, 375);
    press(1'b1, 3);  chk("temp_450", target_temp, 450);
    press(1'b1, 4);  chk("temp_clamp_500", target_temp, 500);

    // down in steps of 100, clamped at 65
    sw = 6'b010000;
    press(1'b0, 3);  chk("temp_200", target_temp, 200);
    press(1'b0, 1);  chk("temp_100", target_temp, 100);
    press(1'b0, 1);  chk("temp_clamp_65", target_temp, 65);
    press(1'b0, 1);  chk("temp_hold_65", target_temp, 65);

    // invalid step pattern, then a long double-key hold
    sw = 6'b001010;
    press(1'b1, 1);  chk("temp_bad_step", target_temp, 65);
    confirm(10);
    chk("cfm_to_set_time", state, 2);
    chk("cfm_no_inc", target_temp, 65);

    // time = 10, enter COOK and count all the way down
    sw = 6'b000010;
    press(1'b1, 1);  chk("time_10", target_time, 10);
    key_inc_n = 1'b0; key_dec_n = 1'b0;
    repeat (4) @(negedge clk);
    chk("cook_entry", state, 3);
    chk("cook_remain_10", remain_time, 10);
    chk("cook_heater", heater_on, 1);
    key_inc_n = 1'b1; key_dec_n = 1'b1;
    repeat (36) @(negedge clk);
    chk("remain_1", remain_time, 1);
    repeat (3) @(negedge clk);
    chk("still_cook", state, 3);
    chk("no_early_done", done_pulse, 0);
    @(negedge clk);
    chk("done_state", state, 4);
    chk("done_remain", remain_time, 0);
    chk("done_pulse_hi", done_pulse, 1);
    chk("done_heater", heater_on, 0);
    @(negedge clk);
    chk("done_pulse_lo", done_pulse, 0);
    chk("done_hold", state, 4);

    confirm(4);
    chk("done_to_set_temp", state, 1);
    chk("kept_temp", target_temp, 65);
    chk("kept_time", target_time, 10);

    // pause for 20 clk in the middle of a cook cycle
    confirm(4);
    confirm(4);
    chk("cook_again", state, 3);
    chk("cook_remain_9", remain_time, 9);
    sw = 6'b100010;
    repeat (20) @(negedge clk);
    chk("pause_frozen", remain_time, 9);
    chk("pause_heater", heater_on, 0);
    chk("pause_state", state, 3);
    sw = 6'b000010;
    repeat (3) @(negedge clk);
    chk("resume_not_yet", remain_time, 9);
    chk("resume_heater", heater_on, 1);
    @(negedge clk);
    chk("resume_8", remain_time, 8);

    // power loss during COOK
    pwr = 1'b0;
    @(negedge clk);
    chk("pwr_off_state",  state, 0);
    chk("pwr_off_temp",   target_temp, 300);
    chk("pwr_off_time",   target_time, 0);
    chk("pwr_off_remain", remain_time, 0);
    chk("pwr_off_heater", heater_on, 0);
    pwr = 1'b1;
    @(negedge clk);
    chk("pwr_on_state", state, 1);
    confirm(4);
    chk("zero_time_set_time", state, 2);
    confirm(4);
    chk("zero_time_ignored", state, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
